// File: rtl/fade_pkg.sv
// Shared types for the RGB hue-wheel fade sequencer.
//   phase_e     : hue phase, encoded 0..5 in wheel order
//   chan_e      : selects one of the three colour channels
//   ramp_t      : the ramping channel plus its direction
//   phase_ramp(): maps a phase to the channel that ramps in it
package fade_pkg;

  typedef enum logic [2:0] {
    PH_G_UP = 3'd0,
    PH_R_DN = 3'd1,
    PH_B_UP = 3'd2,
    PH_G_DN = 3'd3,
    PH_R_UP = 3'd4,
    PH_B_DN = 3'd5
  } phase_e;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } chan_e;

  typedef struct packed {
    chan_e ch;
    logic  up;
  } ramp_t;

  function automatic ramp_t phase_ramp(phase_e ph);
    ramp_t r;
    r.ch = CH_G;
    r.up = 1'b1;
    case (ph)
      PH_G_UP: begin r.ch = CH_G; r.up = 1'b1; end
      PH_R_DN: begin r.ch = CH_R; r.up = 1'b0; end
      PH_B_UP: begin r.ch = CH_B; r.up = 1'b1; end
      PH_G_DN: begin r.ch = CH_G; r.up = 1'b0; end
      PH_R_UP: begin r.ch = CH_R; r.up = 1'b1; end
      PH_B_DN: begin r.ch = CH_B; r.up = 1'b0; end
      default: begin r.ch = CH_G; r.up = 1'b1; end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fade_step_timer.sv
// Counts PWM period completions and fires a single-cycle step every
// PERIODS_PER_STEP periods.
//   clk, rst_n      : clock, async active-low reset
//   en              : count enable; when low the count holds
//   clear           : synchronous clear, overrides en
//   pwm_period_end  : one-cycle period-wrap pulse
//   step            : combinational, high on the pulse that completes a step
module fade_step_timer #(
  parameter int unsigned PERIODS_PER_STEP = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clear,
  input  logic pwm_period_end,
  output logic step
);

  localparam int unsigned CW = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
  localparam logic [CW-1:0] TC = CW'(PERIODS_PER_STEP - 1);

  logic [CW-1:0] r_cnt;
  logic          w_count;
  logic          w_tc;

  assign w_count = en & pwm_period_end & ~clear;
  assign w_tc    = (r_cnt == TC);
  assign step    = w_count & w_tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (w_count) begin
      r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Steps the three RGB PWM duty values around a hue wheel. One channel
// ramps per phase by INC_STEP every PERIODS_PER_STEP PWM periods; duties
// only change on the cycle after a period wrap.
//   clk, rst_n            : clock, async active-low reset
//   en                    : 1 = fade runs, 0 = freeze all state
//   restart               : synchronous return to the reset state (pulses duty_valid)
//   pwm_period_end        : period-wrap pulse from the PWM datapath
//   duty_r/g/b            : registered duty values, 0..PWM_INTERVAL
//   duty_valid            : one-cycle pulse when duties change
//   phase                 : current hue phase 0..5
//
// phase   | meaning
// PH_G_UP | R max, G ramps up,   B 0
// PH_R_DN | G max, R ramps down, B 0
// PH_B_UP | G max, B ramps up,   R 0
// PH_G_DN | B max, G ramps down, R 0
// PH_R_UP | B max, R ramps up,   G 0
// PH_B_DN | R max, B ramps down, G 0
module rgb_fade_sequencer
  import fade_pkg::*;
#(
  parameter  int unsigned PWM_INTERVAL     = 1200,
  parameter  int unsigned INC_STEP         = 10,
  parameter  int unsigned PERIODS_PER_STEP = 4,
  localparam int unsigned DW               = $clog2(PWM_INTERVAL + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          restart,
  input  logic          pwm_period_end,
  output logic [DW-1:0] duty_r,
  output logic [DW-1:0] duty_g,
  output logic [DW-1:0] duty_b,
  output logic          duty_valid,
  output logic [2:0]    phase
);

  if (PWM_INTERVAL % INC_STEP != 0) begin : g_bad_step
    $error("PWM_INTERVAL must be a multiple of INC_STEP");
  end
  if (PERIODS_PER_STEP < 1) begin : g_bad_pps
    $error("PERIODS_PER_STEP must be at least 1");
  end
  if (PWM_INTERVAL < 2) begin : g_bad_interval
    $error("PWM_INTERVAL must be at least 2");
  end

  localparam logic [DW-1:0] FULL    = DW'(PWM_INTERVAL);
  localparam logic [DW-1:0] INC     = DW'(INC_STEP);
  localparam logic [DW-1:0] TOP_PRE = DW'(PWM_INTERVAL - INC_STEP);

  logic [DW-1:0] r_duty_r, r_duty_g, r_duty_b;
  logic          r_valid;
  phase_e        r_phase;

  logic          w_step;
  ramp_t         w_ramp;
  logic [DW-1:0] w_cur;
  logic [DW-1:0] w_next;
  logic          w_at_limit;
  phase_e        w_phase_nxt;

  fade_step_timer #(
    .PERIODS_PER_STEP(PERIODS_PER_STEP)
  ) u_timer (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .clear          (restart),
    .pwm_period_end (pwm_period_end),
    .step           (w_step)
  );

  // Limit is detected on the pre-step value, so the add/subtract can never
  // wrap past full scale or below zero.
  always_comb begin
    w_ramp = phase_ramp(r_phase);
    case (w_ramp.ch)
      CH_R:    w_cur = r_duty_r;
      CH_G:    w_cur = r_duty_g;
      default: w_cur = r_duty_b;
    endcase
    w_next      = w_ramp.up ? (w_cur + INC) : (w_cur - INC);
    w_at_limit  = w_ramp.up ? (w_cur == TOP_PRE) : (w_cur == INC);
    w_phase_nxt = (r_phase == PH_B_DN) ? PH_G_UP : phase_e'(r_phase + 3'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty_r <= FULL;
      r_duty_g <= '0;
      r_duty_b <= '0;
      r_phase  <= PH_G_UP;
      r_valid  <= 1'b0;
    end else if (restart) begin
      r_duty_r <= FULL;
      r_duty_g <= '0;
      r_duty_b <= '0;
      r_phase  <= PH_G_UP;
      r_valid  <= 1'b1;
    end else begin
      r_valid <= w_step;
      if (w_step) begin
        case (w_ramp.ch)
          CH_R:    r_duty_r <= w_next;
          CH_G:    r_duty_g <= w_next;
          default: r_duty_b <= w_next;
        endcase
        if (w_at_limit) begin
          r_phase <= w_phase_nxt;
        end
      end
    end
  end

  assign duty_r     = r_duty_r;
  assign duty_g     = r_duty_g;
  assign duty_b     = r_duty_b;
  assign duty_valid = r_valid;
  assign phase      = r_phase;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Self-checking bench for rgb_fade_sequencer. The reference model tracks
// only the number of completed steps and the period count; duties and phase
// are derived arithmetically from the step count around the hue wheel.
module tb_rgb_fade_sequencer;

  localparam int PI       = 1200;
  localparam int INC      = 10;
  localparam int PPS      = 4;
  localparam int DW       = $clog2(PI + 1);
  localparam int STEPS_PH = PI / INC;
  localparam int STEPS_WH = 6 * STEPS_PH;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          restart;
  logic          pwm_period_end;
  logic [DW-1:0] duty_r, duty_g, duty_b;
  logic          duty_valid;
  logic [2:0]    phase;

  int n_chk  = 0;
  int n_fail = 0;
  int m_s    = 0;
  int m_cnt  = 0;
  bit m_valid = 1'b0;
  int n_valid = 0;
  int pr, pg, pb;

  rgb_fade_sequencer #(
    .PWM_INTERVAL     (PI),
    .INC_STEP         (INC),
    .PERIODS_PER_STEP (PPS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .restart        (restart),
    .pwm_period_end (pwm_period_end),
    .duty_r         (duty_r),
    .duty_g         (duty_g),
    .duty_b         (duty_b),
    .duty_valid     (duty_valid),
    .phase          (phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_duties(input int s, output int r, output int g,
                                       output int b, output int ph);
    int lvl;
    ph  = (s / STEPS_PH) % 6;
    lvl = (s % STEPS_PH) * INC;
    case (ph)
      0:       begin r = PI;       g = lvl;      b = 0;        end
      1:       begin r = PI - lvl; g = PI;       b = 0;        end
      2:       begin r = 0;        g = PI;       b = lvl;      end
      3:       begin r = 0;        g = PI - lvl; b = PI;       end
      4:       begin r = lvl;      g = 0;        b = PI;       end
      default: begin r = PI;       g = 0;        b = PI - lvl; end
    endcase
  endfunction

  task automatic tick(input bit pe, input bit e, input bit rs);
    int er, eg, eb, eph, nch, noth;
    int d[3];
    pwm_period_end = pe;
    en             = e;
    restart        = rs;
    @(posedge clk);
    if (rs) begin
      m_cnt = 0; m_s = 0; m_valid = 1'b1;
    end else if (e && pe) begin
      if (m_cnt == PPS - 1) begin
        m_cnt = 0; m_s = (m_s + 1) % STEPS_WH; m_valid = 1'b1;
      end else begin
        m_cnt++; m_valid = 1'b0;
      end
    end else begin
      m_valid = 1'b0;
    end
    #1;
    pwm_period_end = 1'b0;
    restart        = 1'b0;
    model_duties(m_s, er, eg, eb, eph);
    chk("outputs", {duty_r, duty_g, duty_b, phase, duty_valid},
        {DW'(er), DW'(eg), DW'(eb), 3'(eph), m_valid});
    if (duty_valid && !rs) begin
      n_valid++;
      d[0] = int'(duty_r) - pr;
      d[1] = int'(duty_g) - pg;
      d[2] = int'(duty_b) - pb;
      nch = 0; noth = 0;
      for (int i = 0; i < 3; i++) begin
        if (d[i] == INC || d[i] == -INC) nch++;
        else if (d[i] != 0) noth++;
      end
      chk("one_channel", (nch == 1 && noth == 0), 1);
    end
    pr = int'(duty_r); pg = int'(duty_g); pb = int'(duty_b);
  endtask

  task automatic pulses(input int n, input bit e);
    int gap;
    for (int i = 0; i < n; i++) begin
      tick(1'b1, e, 1'b0);
      gap = $urandom_range(0, 2);
      repeat (gap) tick(1'b0, e, 1'b0);
    end
  endtask

  initial begin
    int nv0;
    rst_n = 1'b0; en = 1'b0; restart = 1'b0; pwm_period_end = 1'b0;
    #12;
    chk("rst_r", duty_r, PI);
    chk("rst_g", duty_g, 0);
    chk("rst_b", duty_b, 0);
    chk("rst_phase", phase, 0);
    chk("rst_valid", duty_valid, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    pr = PI; pg = 0; pb = 0;

    // first step
    n_valid = 0;
    pulses(3, 1'b1);
    chk("pre_step_g", duty_g, 0);
    chk("pre_step_valids", n_valid, 0);
    tick(1'b1, 1'b1, 1'b0);
    chk("step1_g", duty_g, 10);
    chk("step1_valid", duty_valid, 1);
    chk("step1_r", duty_r, PI);
    chk("step1_b", duty_b, 0);
    tick(1'b0, 1'b1, 1'b0);
    chk("step1_valid_drop", duty_valid, 0);

    // phase boundary at 480 pulses
    pulses(475, 1'b1);
    chk("pre_bound_g", duty_g, PI - INC);
    chk("pre_bound_phase", phase, 0);
    tick(1'b1, 1'b1, 1'b0);
    chk("bound_g", duty_g, PI);
    chk("bound_phase", phase, 1);
    chk("bound_valid", duty_valid, 1);
    pulses(4, 1'b1);
    chk("p1_r", duty_r, PI - INC);

    // rest of the full wheel (2880 pulses total)
    pulses(2880 - 484, 1'b1);
    chk("wheel_phase", phase, 0);
    chk("wheel_r", duty_r, PI);
    chk("wheel_g", duty_g, 0);
    chk("wheel_b", duty_b, 0);
    chk("wheel_updates", n_valid, 720);

    // freeze
    pulses(2, 1'b1);
    nv0 = n_valid;
    pulses(10, 1'b0);
    chk("freeze_valids", n_valid - nv0, 0);
    chk("freeze_g", duty_g, 0);
    tick(1'b1, 1'b1, 1'b0);
    chk("resume_g_hold", duty_g, 0);
    tick(1'b1, 1'b1, 1'b0);
    chk("resume_g", duty_g, 10);
    chk("resume_valid", duty_valid, 1);

    // restart colliding with a qualifying step mid-P2
    pulses(289 * PPS + 3, 1'b1);
    chk("p2_b", duty_b, 500);
    chk("p2_phase", phase, 2);
    tick(1'b1, 1'b1, 1'b1);
    chk("rs_r", duty_r, PI);
    chk("rs_g", duty_g, 0);
    chk("rs_b", duty_b, 0);
    chk("rs_phase", phase, 0);
    chk("rs_valid", duty_valid, 1);
    pulses(3, 1'b1);
    chk("rs_cnt_hold", duty_g, 0);
    tick(1'b1, 1'b1, 1'b0);
    chk("rs_cnt_step", duty_g, 10);

    // random mix of en, pulses and restarts
    repeat (400) tick(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 40) == 0));

    // asynchronous reset mid-cycle
    pulses(8, 1'b1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_r", duty_r, PI);
    chk("arst_g", duty_g, 0);
    chk("arst_b", duty_b, 0);
    chk("arst_phase", phase, 0);
    chk("arst_valid", duty_valid, 0);
    m_s = 0; m_cnt = 0; m_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    pr = PI; pg = 0; pb = 0;
    pulses(8, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
